// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I controller and its datapath:
// state encoding, opcodes, ALU codes, mux encodings and the per-state control table.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_JALR_ADR,
    S_JUMP,
    S_LUI,
    S_AUIPC,
    S_HALT,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
  localparam logic [1:0] SRC_A_ZERO   = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;
  localparam logic [1:0] SRC_B_ZERO = 2'b11;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MEM_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;

  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       instruction_or_data;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_control;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_write:           1'b0,
    reg_write:           1'b0,
    ir_write:            1'b0,
    pc_write:            1'b0,
    instruction_or_data: 1'b0,
    result_src:          RES_ALU_OUT,
    alu_src_a:           SRC_A_PC,
    alu_src_b:           SRC_B_RS2,
    alu_control:         ALU_ADD
  };

  function automatic state_e next_state(input state_e s, input logic [6:0] opcode);
    state_e n;
    n = S_INIT;
    case (s)
      S_INIT:     n = S_FETCH;
      S_FETCH:    n = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: n = S_MEMADR;
          OP_R:              n = S_EXEC_R;
          OP_I:              n = S_EXEC_I;
          OP_BRANCH:         n = S_BRANCH;
          OP_JAL:            n = S_JUMP;
          OP_JALR:           n = S_JALR_ADR;
          OP_LUI:            n = S_LUI;
          OP_AUIPC:          n = S_AUIPC;
          OP_SYSTEM:         n = S_HALT;
          default:           n = S_TRAP;
        endcase
      end
      S_MEMADR:   n = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = S_MEMWB;
      S_MEMWB:    n = S_FETCH;
      S_MEMWRITE: n = S_FETCH;
      S_EXEC_R:   n = S_ALUWB;
      S_EXEC_I:   n = S_ALUWB;
      S_ALUWB:    n = S_FETCH;
      S_BRANCH:   n = S_FETCH;
      S_JALR_ADR: n = S_JUMP;
      S_JUMP:     n = S_ALUWB;
      S_LUI:      n = S_ALUWB;
      S_AUIPC:    n = S_ALUWB;
      S_HALT:     n = S_HALT;
      S_TRAP:     n = S_TRAP;
      default:    n = S_INIT;
    endcase
    return n;
  endfunction

  // Control word for a state; branch pc_write is added by the top from branch_taken.
  function automatic ctrl_t ctrl_for(input state_e s, input logic [3:0] exec_op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRC_A_PC;
        c.alu_src_b  = SRC_B_FOUR;
        c.result_src = RES_ALU_RESULT;
      end
      S_DECODE, S_AUIPC: begin
        c.alu_src_a = SRC_A_OLD_PC;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        c.alu_src_a = SRC_A_RS1;
        c.alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: begin
        c.instruction_or_data = 1'b1;
        c.result_src          = RES_ALU_OUT;
      end
      S_MEMWB: begin
        c.result_src = RES_MEM_DATA;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: c.mem_write = 1'b1;
      S_EXEC_R: begin
        c.alu_src_a   = SRC_A_RS1;
        c.alu_src_b   = SRC_B_RS2;
        c.alu_control = exec_op;
      end
      S_EXEC_I: begin
        c.alu_src_a   = SRC_A_RS1;
        c.alu_src_b   = SRC_B_IMM;
        c.alu_control = exec_op;
      end
      S_ALUWB: begin
        c.result_src = RES_ALU_OUT;
        c.reg_write  = 1'b1;
      end
      S_BRANCH: c.result_src = RES_ALU_OUT;
      S_JUMP: begin
        c.result_src = RES_ALU_OUT;
        c.pc_write   = 1'b1;
        c.alu_src_a  = SRC_A_OLD_PC;
        c.alu_src_b  = SRC_B_FOUR;
      end
      S_LUI: begin
        c.alu_src_a = SRC_A_ZERO;
        c.alu_src_b = SRC_B_IMM;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and the RV32I datapath (slave).
interface multicycle_controller_if;
  logic [31:0] instr;
  logic        zero_flag;
  logic        branch_taken;
  logic        mem_write;
  logic        reg_write;
  logic        ir_write;
  logic        pc_write;
  logic        instruction_or_data;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  branch_type;
  logic [3:0]  alu_control;
  logic        halted;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  instr, zero_flag, branch_taken,
    output mem_write, reg_write, ir_write, pc_write, instruction_or_data,
           result_src, alu_src_a, alu_src_b, branch_type, alu_control,
           halted, illegal, instret
  );

  modport slave (
    output instr, zero_flag, branch_taken,
    input  mem_write, reg_write, ir_write, pc_write, instruction_or_data,
           result_src, alu_src_a, alu_src_b, branch_type, alu_control,
           halted, illegal, instret
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] of an R- or I-type instruction to an ALU operation code.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic       is_r,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  always_comb begin
    // NOTE: default assigned first so every path drives alu_control and no latch is inferred.
    alu_control = ALU_ADD;
    case (funct3)
      3'b000: alu_control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the datapath enables and selects, counts retired instructions.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_e      state;
  state_e      nxt;
  ctrl_t       ctrl_q;
  logic        halted_q;
  logic        illegal_q;
  logic [31:0] instret_q;
  logic [3:0]  dec_alu;
  logic        unused_bits;

  alu_decoder u_alu_decoder (
    .is_r        (bus.instr[6:0] == OP_R),
    .funct3      (bus.instr[14:12]),
    .funct7_5    (bus.instr[30]),
    .alu_control (dec_alu)
  );

  assign nxt = next_state(state, bus.instr[6:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_INIT;
      ctrl_q    <= CTRL_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      // NOTE: non-blocking updates; outputs are loaded with the control word of the
      // state being entered, so they are registered Moore outputs with no glitches.
      state  <= nxt;
      ctrl_q <= ctrl_for(nxt, dec_alu);
      if (nxt == S_HALT) halted_q  <= 1'b1;
      if (nxt == S_TRAP) illegal_q <= 1'b1;
      if (nxt == S_FETCH && state != S_INIT) instret_q <= instret_q + 32'd1;
    end
  end

  assign bus.mem_write           = ctrl_q.mem_write;
  assign bus.reg_write           = ctrl_q.reg_write;
  assign bus.ir_write            = ctrl_q.ir_write;
  // Branch condition is only valid once the register file has been read, so sample it in S_BRANCH.
  assign bus.pc_write            = ctrl_q.pc_write | ((state == S_BRANCH) & bus.branch_taken);
  assign bus.instruction_or_data = ctrl_q.instruction_or_data;
  assign bus.result_src          = ctrl_q.result_src;
  assign bus.alu_src_a           = ctrl_q.alu_src_a;
  assign bus.alu_src_b           = ctrl_q.alu_src_b;
  assign bus.alu_control         = ctrl_q.alu_control;
  assign bus.branch_type         = bus.instr[14:12];
  assign bus.halted              = halted_q;
  assign bus.illegal             = illegal_q;
  assign bus.instret             = instret_q;

  // zero_flag is carried for debug visibility only; other IR fields belong to the datapath.
  assign unused_bits = ^{bus.zero_flag, bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle model of the expected control
// sequence for each instruction class plus literal spot checks.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mw;
    logic       rw;
    logic       irw;
    logic       pcw;
    logic       iod;
    logic [1:0] rs;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] alu;
    logic       halted;
    logic       illegal;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        model_q[$];
  logic        model_terminal;
  exp_t        exp_cur;
  logic        exp_valid   = 1'b0;
  logic [31:0] exp_instret = '0;
  logic [31:0] retired     = '0;
  logic [31:0] cur_instr   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] dut_word();
    return {12'h0, bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write,
            bus.instruction_or_data, bus.result_src, bus.alu_src_a, bus.alu_src_b,
            bus.alu_control, bus.halted, bus.illegal, bus.branch_type};
  endfunction

  function automatic logic [31:0] exp_word(input exp_t e, input logic [2:0] bt);
    return {12'h0, e.mw, e.rw, e.irw, e.pcw, e.iod, e.rs, e.a, e.b, e.alu,
            e.halted, e.illegal, bt};
  endfunction

  // ISA semantics of the funct fields: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
  function automatic logic [3:0] alu_of(input logic [31:0] ins);
    logic [2:0] f3;
    logic       is_sub_form;
    f3          = ins[14:12];
    is_sub_form = ins[30];
    case (f3)
      3'd0: return (ins[6:0] == 7'b0110011 && is_sub_form) ? 4'd1 : 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return is_sub_form ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Expected per-cycle outputs for one instruction, starting at its fetch cycle.
  task automatic build(input logic [31:0] ins, input logic bt);
    exp_t e;
    model_q.delete();
    model_terminal = 1'b0;
    e = '0; e.irw = 1; e.pcw = 1; e.b = 2'd1; e.rs = 2'd2; model_q.push_back(e);
    e = '0; e.a = 2'd2; e.b = 2'd2; model_q.push_back(e);
    case (ins[6:0])
      7'b0000011: begin
        e = '0; e.a = 2'd1; e.b = 2'd2; model_q.push_back(e);
        e = '0; e.iod = 1; model_q.push_back(e);
        e = '0; e.rs = 2'd1; e.rw = 1; model_q.push_back(e);
      end
      7'b0100011: begin
        e = '0; e.a = 2'd1; e.b = 2'd2; model_q.push_back(e);
        e = '0; e.mw = 1; model_q.push_back(e);
      end
      7'b0110011, 7'b0010011: begin
        e = '0; e.a = 2'd1; e.b = (ins[6:0] == 7'b0110011) ? 2'd0 : 2'd2;
        e.alu = alu_of(ins); model_q.push_back(e);
        e = '0; e.rw = 1; model_q.push_back(e);
      end
      7'b1100011: begin
        e = '0; e.pcw = bt; model_q.push_back(e);
      end
      7'b1101111, 7'b1100111: begin
        if (ins[6:0] == 7'b1100111) begin
          e = '0; e.a = 2'd1; e.b = 2'd2; model_q.push_back(e);
        end
        e = '0; e.pcw = 1; e.a = 2'd2; e.b = 2'd1; model_q.push_back(e);
        e = '0; e.rw = 1; model_q.push_back(e);
      end
      7'b0110111, 7'b0010111: begin
        e = '0; e.a = (ins[6:0] == 7'b0110111) ? 2'd3 : 2'd2; e.b = 2'd2; model_q.push_back(e);
        e = '0; e.rw = 1; model_q.push_back(e);
      end
      7'b1110011: begin
        model_terminal = 1'b1;
        repeat (3) begin e = '0; e.halted = 1; model_q.push_back(e); end
      end
      default: begin
        model_terminal = 1'b1;
        repeat (3) begin e = '0; e.illegal = 1; model_q.push_back(e); end
      end
    endcase
  endtask

  // Single compare process: every falling edge while an expectation is armed.
  always @(negedge clk) begin
    if (exp_valid) begin
      check("ctrl_word", dut_word(), exp_word(exp_cur, cur_instr[14:12]));
      check("instret", bus.instret, exp_instret);
    end
  end

  task automatic hold_reset();
    #1;
    check("reset_ctrl", dut_word() & ~32'h7, 32'h0);
    check("reset_instret", bus.instret, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset       = 1'b0;
    retired     = '0;
    exp_cur     = '0;
    exp_instret = '0;
    exp_valid   = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    exp_valid = 1'b0;
    hold_reset();
  endtask

  task automatic run_instr(input string tag, input logic [31:0] ins, input logic bt,
                           input int cycles, input logic [31:0] instret_lit,
                           input int pin_idx = -1, input logic [3:0] pin_alu = 4'd0,
                           input int abort_idx = -1);
    logic aborted;
    aborted = 1'b0;
    build(ins, bt);
    if (!model_terminal) check({tag, "_cycles"}, model_q.size(), cycles);
    for (int i = 0; i < model_q.size(); i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        bus.instr        = ins;
        cur_instr        = ins;
        bus.branch_taken = bt;
      end
      exp_cur     = model_q[i];
      exp_instret = retired;
      exp_valid   = 1'b1;
      if (i == 0) check({tag, "_instret_at_fetch"}, bus.instret, instret_lit);
      if (i == pin_idx) check({tag, "_alu_pin"}, bus.alu_control, pin_alu);
      if (i == abort_idx) begin
        @(negedge clk);
        check({tag, "_mem_write_before_reset"}, bus.mem_write, 1);
        #1;
        reset     = 1'b1;
        exp_valid = 1'b0;
        #1;
        check({tag, "_mem_write_after_reset"}, bus.mem_write, 0);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted && !model_terminal) retired++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr        = 32'h0;
    bus.zero_flag    = 1'b0;
    bus.branch_taken = 1'b0;
    hold_reset();

    run_instr("addi",  32'h00500093, 1'b0, 4, 32'd0, 2, 4'd0);
    run_instr("lw",    32'h0000A103, 1'b0, 5, 32'd1);
    run_instr("beq_t", 32'h00208463, 1'b1, 3, 32'd2);
    run_instr("beq_n", 32'h00208463, 1'b0, 3, 32'd3);
    run_instr("sub",   32'h40208033, 1'b0, 4, 32'd4, 2, 4'd1);
    run_instr("srli",  32'h0020D013, 1'b0, 4, 32'd5, 2, 4'd6);
    run_instr("srai",  32'h4020D013, 1'b0, 4, 32'd6, 2, 4'd7);
    run_instr("sw",    32'h0020A023, 1'b0, 4, 32'd7);
    run_instr("jal",   32'h0080006F, 1'b0, 4, 32'd8);
    run_instr("jalr",  32'h000080E7, 1'b0, 5, 32'd9);
    run_instr("lui",   32'h000012B7, 1'b0, 4, 32'd10);
    run_instr("auipc", 32'h00001297, 1'b0, 4, 32'd11);
    run_instr("xor",   32'h0020C033, 1'b0, 4, 32'd12, 2, 4'd4);
    run_instr("slti",  32'h0020A013, 1'b0, 4, 32'd13, 2, 4'd8);
    run_instr("addi_b30", 32'h40008093, 1'b0, 4, 32'd14, 2, 4'd0);

    run_instr("illegal", 32'hFFFFFFFF, 1'b0, 0, 32'd15);
    check("illegal_flag", bus.illegal, 1);
    do_reset();

    run_instr("ecall", 32'h00000073, 1'b0, 0, 32'd0);
    check("halted_flag", bus.halted, 1);
    do_reset();

    run_instr("sw_abort", 32'h0020A023, 1'b0, 4, 32'd0, -1, 4'd0, 3);
    hold_reset();
    run_instr("addi_after_abort", 32'h00500093, 1'b0, 4, 32'd0, 2, 4'd0);
    run_instr("lw_after_abort",   32'h0000A103, 1'b0, 5, 32'd1);

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
